// File: rtl/robot_motion_ctrl.sv
// ==========================================================================
// robot_motion_ctrl : runs front/rotate commands as timed motor actions and
//                     keeps the dead-reckoned grid pose.      Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module robot_motion_ctrl #(
  parameter int POS_W       = 8,
  parameter int MOVE_CYCLES = 4,
  parameter int TURN_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             front,
  input  logic             rotate,
  output logic             cmd_ready,
  output logic             motor_fwd,
  output logic             motor_turn,
  output logic             busy,
  output logic             done,
  output logic [1:0]       heading,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [CNT_W-1:0] move_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_MOVE = 2'd2;

  localparam int MAX_CYC = (MOVE_CYCLES > TURN_CYCLES) ? MOVE_CYCLES : TURN_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_CYCLES - 1);
  localparam logic [TMR_W-1:0] MOVE_LOAD = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic [1:0]       r_heading;
  logic [1:0]       w_heading_nxt;
  logic [POS_W-1:0] r_pos_x;
  logic [POS_W-1:0] r_pos_y;
  logic [POS_W-1:0] w_pos_x_nxt;
  logic [POS_W-1:0] w_pos_y_nxt;
  logic [CNT_W-1:0] r_move_count;
  logic [CNT_W-1:0] w_move_count_nxt;

  logic r_cmd_ready;
  logic r_busy;
  logic r_motor_fwd;
  logic r_motor_turn;
  logic r_done;
  logic w_cmd_ready_nxt;
  logic w_busy_nxt;
  logic w_motor_fwd_nxt;
  logic w_motor_turn_nxt;
  logic w_done_nxt;

  logic w_accept;
  logic w_tmr_zero;
  logic w_turn_end;
  logic w_move_end;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_tmr_zero = (r_timer == '0);
  assign w_turn_end = (r_state == S_TURN) && w_tmr_zero;
  assign w_move_end = (r_state == S_MOVE) && w_tmr_zero;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (rotate) begin
            w_state_nxt = S_TURN;
          end else if (front) begin
            w_state_nxt = S_MOVE;
          end
        end
      end
      S_TURN: begin
        if (w_tmr_zero) begin
          w_state_nxt = r_pending ? S_MOVE : S_IDLE;
        end
      end
      S_MOVE: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop
  always_comb begin
    w_cmd_ready_nxt  = (w_state_nxt == S_IDLE);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_motor_fwd_nxt  = (w_state_nxt == S_MOVE);
    w_motor_turn_nxt = (w_state_nxt == S_TURN);
    w_done_nxt       = (w_accept && !rotate && !front)
                     || (w_turn_end && !r_pending)
                     || w_move_end;
  end

  // Timer, pending flag and pose next values
  always_comb begin
    w_timer_nxt = r_timer;
    if ((w_state_nxt == S_TURN) && (r_state != S_TURN)) begin
      w_timer_nxt = TURN_LOAD;
    end else if ((w_state_nxt == S_MOVE) && (r_state != S_MOVE)) begin
      w_timer_nxt = MOVE_LOAD;
    end else if (!w_tmr_zero) begin
      w_timer_nxt = r_timer - 1'b1;
    end

    w_pending_nxt = r_pending;
    if (w_accept && rotate) begin
      w_pending_nxt = front;
    end else if (w_move_end) begin
      w_pending_nxt = 1'b0;
    end

    w_heading_nxt = r_heading + {1'b0, w_turn_end};

    w_pos_x_nxt      = r_pos_x;
    w_pos_y_nxt      = r_pos_y;
    w_move_count_nxt = r_move_count;
    if (w_move_end) begin
      case (r_heading)
        2'd0:    w_pos_y_nxt = r_pos_y + POS_ONE;
        2'd1:    w_pos_x_nxt = r_pos_x + POS_ONE;
        2'd2:    w_pos_y_nxt = r_pos_y - POS_ONE;
        default: w_pos_x_nxt = r_pos_x - POS_ONE;
      endcase
      if (r_move_count != '1) begin
        w_move_count_nxt = r_move_count + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer      <= '0;
      r_pending    <= 1'b0;
      r_heading    <= 2'd0;
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_move_count <= '0;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_motor_fwd  <= 1'b0;
      r_motor_turn <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_timer      <= w_timer_nxt;
      r_pending    <= w_pending_nxt;
      r_heading    <= w_heading_nxt;
      r_pos_x      <= w_pos_x_nxt;
      r_pos_y      <= w_pos_y_nxt;
      r_move_count <= w_move_count_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_motor_fwd  <= w_motor_fwd_nxt;
      r_motor_turn <= w_motor_turn_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign motor_fwd  = r_motor_fwd;
  assign motor_turn = r_motor_turn;
  assign done       = r_done;
  assign heading    = r_heading;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign move_count = r_move_count;

endmodule

`default_nettype wire

// File: tb/tb_robot_motion_ctrl.sv
// ==========================================================================
// tb_robot_motion_ctrl : scoreboard bench for robot_motion_ctrl.  Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_robot_motion_ctrl;

  localparam int POS_W = 8;
  localparam int MOVE  = 4;
  localparam int TURN  = 2;
  localparam int CNT_W = 4;
  localparam int PMOD  = 2 ** POS_W;
  localparam int MCMAX = 2 ** CNT_W - 1;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             front;
  logic             rotate;
  logic             cmd_ready;
  logic             motor_fwd;
  logic             motor_turn;
  logic             busy;
  logic             done;
  logic [1:0]       heading;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [CNT_W-1:0] move_count;

  robot_motion_ctrl #(
    .POS_W(POS_W), .MOVE_CYCLES(MOVE), .TURN_CYCLES(TURN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .front(front), .rotate(rotate),
    .cmd_ready(cmd_ready), .motor_fwd(motor_fwd), .motor_turn(motor_turn),
    .busy(busy), .done(done), .heading(heading), .pos_x(pos_x), .pos_y(pos_y),
    .move_count(move_count)
  );

  typedef struct {
    int h;
    int x;
    int y;
    int mc;
    int busy_c;
    int turn_c;
    int fwd_c;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference pose and the number of busy cycles still owed by the current action
  int m_h = 0, m_x = 0, m_y = 0, m_mc = 0;
  int ref_wait = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_accept(input bit f, input bit r);
    exp_t e;
    int   d = 0;
    if (r) begin
      m_h = (m_h + 1) % 4;
      d += TURN;
    end
    if (f) begin
      case (m_h)
        0: m_y = (m_y + 1) % PMOD;
        1: m_x = (m_x + 1) % PMOD;
        2: m_y = (m_y + PMOD - 1) % PMOD;
        default: m_x = (m_x + PMOD - 1) % PMOD;
      endcase
      if (m_mc < MCMAX) m_mc++;
      d += MOVE;
    end
    e.h = m_h; e.x = m_x; e.y = m_y; e.mc = m_mc;
    e.busy_c = d;
    e.turn_c = r ? TURN : 0;
    e.fwd_c  = f ? MOVE : 0;
    sb_q.push_back(e);
    ref_wait = d;
  endtask

  // One negedge: check readiness, then drive the command (or junk while busy)
  task automatic step(input bit v, input bit f, input bit r, output bit acc);
    bit er;
    @(negedge clk);
    er = (ref_wait == 0);
    chk("cmd_ready", cmd_ready, er);
    if (ref_wait > 0) ref_wait--;
    acc = 1'b0;
    if (er) begin
      cmd_valid = v; front = f; rotate = r;
      if (v) begin
        model_accept(f, r);
        acc = 1'b1;
      end
    end else begin
      cmd_valid = 1'($urandom_range(1, 0));
      front     = 1'($urandom_range(1, 0));
      rotate    = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic issue(input bit f, input bit r);
    bit a;
    int n = 0;
    do begin
      step(1'b1, f, r, a);
      n++;
    end while (!a && n < 100);
    if (!a) begin
      total++; bad++;
      $display("FAIL issue_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, 1'b0, 1'b0, a);
  endtask

  // Called at a negedge: asserts reset there, checks reset values, releases
  task automatic rst_body();
    reset = 1'b1; cmd_valid = 1'b0; front = 1'b0; rotate = 1'b0;
    sb_q.delete();
    m_h = 0; m_x = 0; m_y = 0; m_mc = 0; ref_wait = 0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_motor_fwd", motor_fwd, 0);
    chk("rst_motor_turn", motor_turn, 0);
    chk("rst_done", done, 0);
    chk("rst_heading", heading, 0);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_pos_y", pos_y, 0);
    chk("rst_move_count", move_count, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_body();
  endtask

  // Monitor: accumulates per-action activity and checks it at each done pulse
  initial begin
    int   c_busy = 0, c_turn = 0, c_fwd = 0;
    int   l_x = 0, l_y = 0, l_mc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        c_busy = 0; c_turn = 0; c_fwd = 0;
        l_x = 0; l_y = 0; l_mc = 0;
      end else begin
        chk("motor_overlap", {31'd0, motor_fwd & motor_turn}, 0);
        chk("busy_vs_ready", busy, !cmd_ready);
        if (!busy) chk("idle_motors", {motor_fwd, motor_turn}, 0);
        if (busy) begin
          chk("stable_pos_x", pos_x, l_x);
          chk("stable_pos_y", pos_y, l_y);
          chk("stable_move_count", move_count, l_mc);
        end
        c_busy += busy;
        c_turn += motor_turn;
        c_fwd  += motor_fwd;
        if (done) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending command (t=%0t)", $time);
          end else begin
            e = sb_q.pop_front();
            chk("heading", heading, e.h);
            chk("pos_x", pos_x, e.x);
            chk("pos_y", pos_y, e.y);
            chk("move_count", move_count, e.mc);
            chk("busy_cycles", c_busy, e.busy_c);
            chk("turn_cycles", c_turn, e.turn_c);
            chk("fwd_cycles", c_fwd, e.fwd_c);
            l_x = e.x; l_y = e.y; l_mc = e.mc;
          end
          c_busy = 0; c_turn = 0; c_fwd = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; front = 1'b0; rotate = 1'b0;
    @(negedge clk);
    rst_body();

    // Single forward step from heading N
    issue(1'b1, 1'b0);
    idle(8);

    // Four back-to-back right turns
    repeat (4) issue(1'b0, 1'b1);
    idle(6);

    // Combined turn+move from reset
    do_reset();
    issue(1'b1, 1'b1);
    idle(10);

    // Wrap south past y=0, then a no-op, then junk while busy
    do_reset();
    issue(1'b0, 1'b1);
    issue(1'b0, 1'b1);
    issue(1'b1, 1'b0);
    idle(8);
    issue(1'b0, 1'b0);
    idle(3);
    issue(1'b1, 1'b1);
    idle(10);

    // Reset during the second cycle of a move from pose (1,1)
    do_reset();
    issue(1'b1, 1'b0);
    issue(1'b1, 1'b1);
    issue(1'b1, 1'b0);
    idle(1);
    @(negedge clk);
    chk("fwd_before_reset", motor_fwd, 1);
    rst_body();
    issue(1'b1, 1'b0);
    idle(8);

    // Randomized traffic; enough moves to saturate move_count
    for (int i = 0; i < 160; i++) begin
      issue(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(9, 0) < 3) idle($urandom_range(3, 0));
    end
    idle(20);
    chk("scoreboard_empty", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/robot_motion_ctrl.md
Name: robot_motion_ctrl

Overview:
- Downstream consumer of the wall-following robot FSM (moore_robot).
- Takes its front/rotate decision as a command and runs it as a timed motor action: right turn, forward step, or both.
- Keeps dead-reckoned grid pose (x, y, heading).
- Issues a ready/valid handshake so the robot FSM advances only after each action has completed.

Parameters:
- POS_W, 8: width of the pos_x/pos_y grid counters (modulo 2^POS_W).
- MOVE_CYCLES, 4: cycles motor_fwd is held per forward step (>=1).
- TURN_CYCLES, 2: cycles motor_turn is held per 90-degree turn (>=1).
- CNT_W, 16: width of the move_count statistic.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  front/rotate command present.
- front  in  1  command: step forward one cell.
- rotate  in  1  command: turn 90 degrees clockwise.
- cmd_ready  out  1  block idle and able to accept a command.
- motor_fwd  out  1  forward drive enable.
- motor_turn  out  1  turn drive enable.
- busy  out  1  action in progress (== ~cmd_ready).
- done  out  1  one-cycle pulse when a command has fully completed.
- heading  out  2  0=N, 1=E, 2=S, 3=W.
- pos_x  out  POS_W  grid x.
- pos_y  out  POS_W  grid y.
- move_count  out  CNT_W  completed forward steps, saturating.

Behaviour:
- One clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, cmd_ready=1, busy=0.
  - motor_fwd=0, motor_turn=0, done=0.
  - heading=0, pos_x=0, pos_y=0, move_count=0, pending-forward flag=0.
- Reset wins over every other event, including mid-action: the action aborts immediately, no pose update, no done.
- States: IDLE, TURN, MOVE. All outputs are registered; motor_fwd is high only in MOVE, motor_turn only in TURN.
- Accept: the edge where cmd_valid && cmd_ready. front/rotate are captured at that edge only; changes while busy are ignored, and cmd_valid while busy is ignored (not queued).
- Accepted command decode:
  - rotate=1: go to TURN. Store front in the pending flag.
  - rotate=0, front=1: go to MOVE.
  - rotate=0, front=0: no-op. Stay IDLE and pulse done on the next cycle. cmd_ready stays 1.
- TURN:
  - Timer loads TURN_CYCLES-1; motor_turn is high for exactly TURN_CYCLES cycles.
  - At the terminal edge, heading <= heading+1 (mod 4).
  - If pending=1, go directly to MOVE with no idle gap. Otherwise go to IDLE and done=1 for the following cycle.
- MOVE:
  - motor_fwd is high for exactly MOVE_CYCLES cycles.
  - At the terminal edge, update pose by heading: N y+1, E x+1, S y-1, W x-1. Arithmetic is modulo 2^POS_W (255+1=0, 0-1=255).
  - move_count increments, saturating at 2^CNT_W-1.
  - Clear pending, go to IDLE, done=1 for one cycle.
- Combined command (front=1, rotate=1): turn first, then move. Exactly one done pulse, after TURN_CYCLES+MOVE_CYCLES busy cycles.
- Latency: accept edge -> first motor cycle is the next cycle. A new command can be accepted in the same cycle done is high, because cmd_ready=1 there.
- Pose outputs change only at action terminal edges and are stable during motor cycles.

Test Plan:
1. Assert reset 2 cycles -> cmd_ready=1, busy=0, motors=0, done=0, heading=0, pos=(0,0), move_count=0.
2. At heading N, accept front=1,rotate=0 -> motor_fwd high exactly 4 cycles; then pos_y=1, move_count=1, done high 1 cycle, cmd_ready=1.
3. Four back-to-back rotate-only commands -> motor_turn high 2 cycles each; heading sequence 1,2,3,0; 4 done pulses; pos unchanged.
4. From reset, accept front=1,rotate=1 -> motor_turn 2 cycles then motor_fwd 4 cycles, no gap; heading=1, pos_x=1, pos_y=0; single done after 6 busy cycles.
5. Wrap case: rotate twice (heading=2), then front from (0,0) -> pos_y=255. Separately, a no-op command (0,0) -> done next cycle, no motor activity. cmd_valid toggling with different front/rotate while busy -> ignored, result unchanged.
6. Reset on cycle 2 of MOVE after pose (1,1) -> motor_fwd drops on the next cycle; pos=(0,0), heading=0, no done; next command executes normally.
